// File: rtl/poly_reduce_pkg.sv
// rtl/poly_reduce_pkg.sv - shared constants and state encoding for the coefficient reduction sequencer
package poly_reduce_pkg;

    localparam int KYBER_K   = 2;
    localparam int KYBER_N   = 256;
    localparam int KYBER_Q   = 3329;
    localparam int BARRETT_V = 20159;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WAIT_RD  = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_WAIT_RED = 3'd4,
        ST_WRITE    = 3'd5,
        ST_FINISH   = 3'd6
    } state_e;

endpackage

// File: rtl/poly_reduce_addr_cnt.sv
// rtl/poly_reduce_addr_cnt.sv - coefficient address counter with clear, increment and terminal flag
module poly_reduce_addr_cnt #(
    parameter int ADDR_W = 9,
    parameter int LAST   = 511
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_next_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Clear wins; the terminal address is held so the counter never wraps
    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (inc_i && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // Address register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_next_o = addr_d;
    assign last_o      = (addr_q == LAST_ADDR);

endmodule

// File: rtl/poly_reduce_ctrl.sv
// rtl/poly_reduce_ctrl.sv - sequencer that Barrett-reduces every coefficient of the vector in place
module poly_reduce_ctrl #(
    parameter int KYBER_K = poly_reduce_pkg::KYBER_K,
    parameter int KYBER_N = poly_reduce_pkg::KYBER_N,
    parameter int COEFF_W = 16,
    parameter int RED_W   = 12,
    parameter int ADDR_W  = $clog2(KYBER_K * KYBER_N),
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_re,
    input  logic [COEFF_W-1:0] ram_rdata,
    output logic               ram_we,
    output logic [COEFF_W-1:0] ram_wdata,
    output logic               red_enable,
    output logic [COEFF_W-1:0] red_coeff,
    input  logic               red_done,
    input  logic [RED_W-1:0]   red_result
);

    import poly_reduce_pkg::*;

    localparam int NUM_COEFF = KYBER_K * KYBER_N;
    localparam int TO_W      = $clog2(TIMEOUT + 1);
    // The counter is compared before it increments, so TIMEOUT-1 here means
    // this WAIT_RED cycle is the TIMEOUT-th one.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e state_q, state_d;

    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               error_q, error_d;
    logic               accept;
    logic               timed_out;
    logic               addr_last;
    logic [ADDR_W-1:0]  addr_next;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ram_re_q, ram_re_d;
    logic               ram_we_q, ram_we_d;
    logic               red_enable_q, red_enable_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [COEFF_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [COEFF_W-1:0] red_coeff_q, red_coeff_d;

    assign accept    = (state_q == ST_IDLE) && start;
    assign timed_out = (state_q == ST_WAIT_RED) && !red_done && (to_cnt_q == TO_LAST);

    poly_reduce_addr_cnt #(
        .ADDR_W (ADDR_W),
        .LAST   (NUM_COEFF - 1)
    ) u_addr_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (accept),
        .inc_i       (state_q == ST_WRITE),
        .addr_next_o (addr_next),
        .last_o      (addr_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one coefficient per READ..WRITE loop, terminal compare before increment
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_READ;
            ST_READ:     state_d = ST_WAIT_RD;
            ST_WAIT_RD:  state_d = ST_LAUNCH;
            ST_LAUNCH:   state_d = ST_WAIT_RED;
            ST_WAIT_RED: begin
                if (red_done) begin
                    state_d = ST_WRITE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_FINISH;
                end
            end
            ST_WRITE:    state_d = addr_last ? ST_FINISH : ST_READ;
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Timeout counter and sticky error: both restart on an accepted start
    always_comb begin
        to_cnt_d = to_cnt_q;
        error_d  = error_q;
        if (accept || (state_q == ST_WRITE)) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT_RED) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (accept) begin
            error_d = 1'b0;
        end else if (timed_out) begin
            error_d = 1'b1;
        end
    end

    // Output decode from the next state so every strobe is a flop aligned with its state
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_FINISH);
        ram_re_d     = (state_d == ST_READ);
        ram_we_d     = (state_d == ST_WRITE);
        red_enable_d = (state_d == ST_LAUNCH);
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        red_coeff_d  = red_coeff_q;
        if ((state_d == ST_READ) || (state_d == ST_WRITE)) begin
            ram_addr_d = addr_next;
        end
        if (state_d == ST_WRITE) begin
            ram_wdata_d = {{(COEFF_W - RED_W){1'b0}}, red_result};
        end
        if (state_q == ST_WAIT_RD) begin
            red_coeff_d = ram_rdata;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q     <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ram_re_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            red_enable_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            red_coeff_q  <= '0;
        end else begin
            to_cnt_q     <= to_cnt_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ram_re_q     <= ram_re_d;
            ram_we_q     <= ram_we_d;
            red_enable_q <= red_enable_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            red_coeff_q  <= red_coeff_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ram_re     = ram_re_q;
    assign ram_we     = ram_we_q;
    assign red_enable = red_enable_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign red_coeff  = red_coeff_q;

endmodule

// File: tb/tb_poly_reduce_ctrl.sv
// tb/tb_poly_reduce_ctrl.sv - scoreboard bench for the coefficient reduction sequencer
module tb_poly_reduce_ctrl;
    import poly_reduce_pkg::*;

    localparam int NUM     = KYBER_K * KYBER_N;
    localparam int AW      = $clog2(NUM);
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          busy, done, error;
    logic [AW-1:0] ram_addr;
    logic          ram_re, ram_we;
    logic [15:0]   ram_rdata, ram_wdata;
    logic          red_enable;
    logic [15:0]   red_coeff;
    logic          red_done;
    logic [11:0]   red_result;

    always #5 clk = ~clk;

    poly_reduce_ctrl #(
        .KYBER_K (KYBER_K),
        .KYBER_N (KYBER_N),
        .COEFF_W (16),
        .RED_W   (12),
        .ADDR_W  (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .red_enable (red_enable),
        .red_coeff  (red_coeff),
        .red_done   (red_done),
        .red_result (red_result)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mathematical reference: signed coefficient mod q into [0, q)
    function automatic logic [15:0] ref_reduce(input logic [15:0] a);
        int v;
        v = int'($signed(a)) % KYBER_Q;
        if (v < 0) v += KYBER_Q;
        return 16'(v);
    endfunction

    // Coefficient RAM with one-cycle read latency
    logic [15:0] mem      [NUM];
    logic [15:0] init_mem [NUM];
    logic        load_req = 1'b0;
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < NUM; i++) mem[i] <= init_mem[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    // Reducer model: done red_lat cycles after enable (0 = never), plus optional stray pulse
    int          red_lat = 5;
    int          left;
    logic        pend;
    logic [15:0] cap;
    logic        stray_req = 1'b0;
    always @(posedge clk) begin
        red_done <= 1'b0;
        if (!reset_n || done) begin
            pend <= 1'b0;
        end else if (red_enable) begin
            pend <= 1'b1;
            left <= red_lat - 1;
            cap  <= red_coeff;
        end else if (pend && red_lat != 0) begin
            if (left <= 1) begin
                red_done   <= 1'b1;
                red_result <= 12'(ref_reduce(cap));
                pend       <= 1'b0;
            end else begin
                left <= left - 1;
            end
        end else if (stray_req) begin
            red_done   <= 1'b1;
            red_result <= 12'hABC;
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;
    typedef struct packed {
        int   cyc;
        logic err;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    int  checks = 0;
    int  errors = 0;
    int  s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        wr_t w;
        dn_t d;
        if (reset_n !== 1'b1) return;
        if (ram_re || ram_we) chk("re_we_exclusive", 32'(ram_re & ram_we), 32'd0);
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%0h, expected no write", ram_addr, ram_wdata);
            end else begin
                w = wr_q.pop_front();
                chk("write_addr", 32'(ram_addr), 32'(w.addr));
                chk("write_data", 32'(ram_wdata), 32'(w.data));
            end
        end
        if (done) begin
            if (dn_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: cycle=%0d, expected no done", cyc);
            end else begin
                d = dn_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(d.cyc));
                chk("done_error", 32'(error), 32'(d.err));
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
        if (red_enable) chk("enable_while_outstanding", 32'(pend), 32'd0);
        if (pend) chk("red_coeff_stable", 32'(red_coeff), 32'(cap));
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_busy"},       32'(busy),       32'd0);
        chk({name, "_done"},       32'(done),       32'd0);
        chk({name, "_error"},      32'(error),      32'd0);
        chk({name, "_ram_re"},     32'(ram_re),     32'd0);
        chk({name, "_ram_we"},     32'(ram_we),     32'd0);
        chk({name, "_red_enable"}, 32'(red_enable), 32'd0);
        chk({name, "_ram_addr"},   32'(ram_addr),   32'd0);
        chk({name, "_ram_wdata"},  32'(ram_wdata),  32'd0);
        chk({name, "_red_coeff"},  32'(red_coeff),  32'd0);
    endtask

    // Copy init_mem into the RAM and queue the expected write-backs
    task automatic load_and_expect(input int lat);
        wr_t w;
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        red_lat  = lat;
        if (lat != 0) begin
            for (int i = 0; i < NUM; i++) begin
                w.addr = AW'(i);
                w.data = ref_reduce(init_mem[i]);
                wr_q.push_back(w);
            end
        end
    endtask

    // Pulse start; so is the cycle (counter value) in which READ is first seen
    task automatic start_run(input int lat, output int so);
        dn_t d;
        @(negedge clk);
        start = 1'b1;
        so    = cyc + 1;
        d.cyc = (lat == 0) ? so + 3 + TIMEOUT : so + (lat + 4) * NUM;
        d.err = (lat == 0);
        dn_q.push_back(d);
        @(negedge clk);
        start = 1'b0;
        chk("busy_first_cycle", 32'(busy), 32'd1);
        chk("re_first_cycle", 32'(ram_re), 32'd1);
        chk("addr_first_cycle", 32'(ram_addr), 32'd0);
        chk("error_cleared_on_start", 32'(error), 32'd0);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while ((dn_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dn_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
            dn_q.delete();
        end
        repeat (2) @(negedge clk);
        chk({name, "_writes_left"}, 32'(wr_q.size()), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        wr_q.delete();
    endtask

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        #1 reset_n = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Every coefficient 4096 -> 767
        for (int i = 0; i < NUM; i++) init_mem[i] = 16'h1000;
        load_and_expect(5);
        start_run(5, s);
        wait_done(9 * NUM + 20, "all_4096");
        chk("mem0_4096", 32'(mem[0]), 32'd767);
        chk("mem_last_4096", 32'(mem[NUM-1]), 32'd767);

        // Stray reducer done while idle must be ignored
        @(negedge clk);
        stray_req = 1'b1;
        @(negedge clk);
        stray_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_done_busy", 32'(busy), 32'd0);

        // Mixed values with a start re-pulse while busy
        for (int i = 0; i < NUM; i++) begin
            case ($urandom_range(0, 5))
                0: init_mem[i] = 16'h0000;
                1: init_mem[i] = 16'h0D00;
                2: init_mem[i] = 16'hF000;
                3: init_mem[i] = 16'h7FFF;
                4: init_mem[i] = 16'h8000;
                default: init_mem[i] = 16'($urandom);
            endcase
        end
        init_mem[0] = 16'h0000;
        init_mem[1] = 16'h0D00;
        init_mem[2] = 16'hF000;
        load_and_expect(5);
        start_run(5, s);
        while (cyc != s + 98) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(9 * NUM + 20, "mixed");
        chk("mixed_addr0", 32'(mem[0]), 32'd0);
        chk("mixed_addr1", 32'(mem[1]), 32'd3328);
        chk("mixed_addr2", 32'(mem[2]), 32'd2562);

        // Reducer that never answers: timeout, no write, sticky error
        for (int i = 0; i < NUM; i++) init_mem[i] = 16'($urandom);
        load_and_expect(0);
        start_run(0, s);
        wait_done(40, "timeout");
        chk("error_sticky", 32'(error), 32'd1);

        // Reset in the middle of a run, then reprocess from address 0
        for (int i = 0; i < NUM; i++) init_mem[i] = 16'($urandom);
        load_and_expect(5);
        start_run(5, s);
        while (cyc != s + 1999) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        wr_q.delete();
        dn_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NUM; i++) init_mem[i] = mem[i];
        load_and_expect(5);
        start_run(5, s);
        wait_done(9 * NUM + 20, "after_reset");

        // Slower reducer: 12 cycles per coefficient
        for (int i = 0; i < NUM; i++) init_mem[i] = 16'($urandom);
        load_and_expect(8);
        start_run(8, s);
        wait_done(12 * NUM + 20, "latency8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
